bw_io_ddr_impctl_cal: RTL and testbench

BW_IO_DDR_IMPCTL_CAL -- requirements
Module: bw_io_ddr_impctl_cal

---
 rtl/bw_io_ddr_pkg.sv | 20 ++
 rtl/bw_io_ddr_impctl_vote.sv | 52 +++++
 rtl/bw_io_ddr_impctl_cal.sv | 141 ++++++++++++++
 tb/tb_bw_io_ddr_impctl_cal.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bw_io_ddr_pkg.sv
// Shared definitions for the DDR pad impedance calibration blocks.
package bw_io_ddr_pkg;

  // Calibration sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    STEP   = 2'd3
  } cal_state_t;

  // Widest impedance code the midpoint helper supports.
  localparam int MAX_CODE_W = 32;

  // Midpoint of a code range (2^(code_w-1)), used as the reset code.
  function automatic logic [MAX_CODE_W-1:0] mid_code(input int code_w);
    return 32'd1 << (code_w - 1);
  endfunction

endpackage

// File: rtl/bw_io_ddr_impctl_vote.sv
// Comparator vote filter: a signed count of consecutive same-direction votes,
// clamped at +/-FILT_DEPTH, restarted from zero whenever the vote direction flips.
module bw_io_ddr_impctl_vote #(
  parameter int FILT_DEPTH = 4
) (
  input  logic rclk,
  input  logic rst,
  input  logic clear,
  input  logic sample,
  input  logic vote_up,
  output logic at_pos,
  output logic hit_lim
);

  localparam int CW = $clog2(FILT_DEPTH + 1) + 1;
  localparam logic signed [CW-1:0] LIM_POS = CW'(FILT_DEPTH);
  localparam logic signed [CW-1:0] LIM_NEG = -LIM_POS;

  logic signed [CW-1:0] count;
  logic signed [CW-1:0] base;
  logic signed [CW-1:0] count_nxt;
  logic                 is_neg;
  logic                 is_pos;

  // Next count: an opposing vote first drops the count to zero, then applies.
  always_comb begin
    is_neg    = count[CW-1];
    is_pos    = !count[CW-1] && (count != '0);
    base      = count;
    count_nxt = count;
    if (vote_up) begin
      if (is_neg) base = '0;
      count_nxt = (base == LIM_POS) ? base : base + CW'(1);
    end else begin
      if (is_pos) base = '0;
      count_nxt = (base == LIM_NEG) ? base : base - CW'(1);
    end
  end

  assign at_pos  = (count == LIM_POS);
  assign hit_lim = sample && ((count_nxt == LIM_POS) || (count_nxt == LIM_NEG));

  // Vote count register; clear wins over a sample in the same cycle.
  always_ff @(posedge rclk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (sample) begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/bw_io_ddr_impctl_cal.sv
// Impedance calibration controller for one pullup or pulldown leg group.
// Tracks the pad comparator with a filtered up/down code and forwards it to
// the driver legs unless frozen; a CSR write overrides both codes.
module bw_io_ddr_impctl_cal
  import bw_io_ddr_pkg::*;
#(
  parameter int CODE_W     = 8,
  parameter int FILT_DEPTH = 4,
  parameter int SETTLE_CYC = 7,
  parameter int DELTA_THR  = 2
) (
  input  logic              rclk,
  input  logic              rst,
  input  logic              cal_en,
  input  logic              cmp_in,
  input  logic              freeze,
  input  logic              we_csr,
  input  logic [CODE_W-1:0] from_csr,
  output logic [CODE_W-1:0] z,
  output logic [CODE_W-1:0] to_csr,
  output logic              deltabit,
  output logic              locked,
  output logic              update_pulse
);

  localparam logic [CODE_W-1:0] MID_CODE    = CODE_W'(mid_code(CODE_W));
  localparam int                SCW         = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SCW-1:0]    SETTLE_LAST = SCW'(SETTLE_CYC - 1);
  localparam logic [CODE_W:0]   DELTA_LIM   = (CODE_W + 1)'(DELTA_THR);

  cal_state_t        state;
  cal_state_t        state_nxt;
  logic [SCW-1:0]    settle_cnt;
  logic [1:0]        rev_cnt;
  logic              dir_valid;
  logic              dir_down;
  logic              vote_clear;
  logic              vote_sample;
  logic              vote_at_pos;
  logic              vote_hit;
  logic              settle_done;
  logic              at_limit;
  logic              step_ok;
  logic              reversal;
  logic [CODE_W-1:0] code_step;
  logic [CODE_W:0]   diff;
  logic [CODE_W:0]   mag;
  logic              delta_hit;

  assign vote_clear  = (state == IDLE) || (state == STEP) || we_csr || !cal_en;
  assign vote_sample = (state == SAMPLE);
  assign locked      = (rev_cnt == 2'd2);

  bw_io_ddr_impctl_vote #(
    .FILT_DEPTH(FILT_DEPTH)
  ) u_vote (
    .rclk   (rclk),
    .rst    (rst),
    .clear  (vote_clear),
    .sample (vote_sample),
    .vote_up(cmp_in),
    .at_pos (vote_at_pos),
    .hit_lim(vote_hit)
  );

  // Next state: CSR write overrides a disable, which overrides normal sequencing.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cal_en) state_nxt = SETTLE;
      SETTLE:  if (settle_done) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = vote_hit ? STEP : SETTLE;
      STEP:    state_nxt = SETTLE;
      default: state_nxt = IDLE;
    endcase
    if (!cal_en) state_nxt = IDLE;
    if (we_csr)  state_nxt = cal_en ? SETTLE : IDLE;
  end

  // Step direction, saturation, reversal detection and code distance.
  always_comb begin
    settle_done = (settle_cnt == SETTLE_LAST);
    at_limit    = vote_at_pos ? (to_csr == '0) : (to_csr == {CODE_W{1'b1}});
    step_ok     = (state == STEP) && !at_limit;
    code_step   = vote_at_pos ? (to_csr - CODE_W'(1)) : (to_csr + CODE_W'(1));
    reversal    = step_ok && dir_valid && (dir_down != vote_at_pos);
    diff        = {1'b0, to_csr} - {1'b0, z};
    mag         = diff[CODE_W] ? (~diff + 1'b1) : diff;
    delta_hit   = (mag >= DELTA_LIM);
  end

  // State register.
  always_ff @(posedge rclk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Settle timer, code registers, step history and status outputs.
  always_ff @(posedge rclk) begin
    if (rst) begin
      settle_cnt   <= '0;
      to_csr       <= MID_CODE;
      z            <= MID_CODE;
      update_pulse <= 1'b0;
      deltabit     <= 1'b0;
      dir_valid    <= 1'b0;
      dir_down     <= 1'b0;
      rev_cnt      <= '0;
    end else begin
      settle_cnt   <= ((state == SETTLE) && (state_nxt == SETTLE) && !we_csr)
                      ? settle_cnt + SCW'(1) : '0;
      deltabit     <= delta_hit;
      update_pulse <= 1'b0;
      if (we_csr) begin
        to_csr       <= from_csr;
        z            <= from_csr;
        update_pulse <= (z != from_csr);
        dir_valid    <= 1'b0;
        rev_cnt      <= '0;
      end else if (!cal_en) begin
        dir_valid <= 1'b0;
        rev_cnt   <= '0;
      end else begin
        if (step_ok) begin
          to_csr    <= code_step;
          dir_valid <= 1'b1;
          dir_down  <= vote_at_pos;
          if (reversal && (rev_cnt != 2'd2)) rev_cnt <= rev_cnt + 2'd1;
        end
        if (!freeze && (z != to_csr)) begin
          z            <= to_csr;
          update_pulse <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bw_io_ddr_impctl_cal.sv
// Self-checking bench for bw_io_ddr_impctl_cal with default parameters.
// A round-level reference model predicts every z update into a queue; a
// monitor pops one entry per update_pulse and compares the applied code.
module tb_bw_io_ddr_impctl_cal;

  localparam int MID  = 128;
  localparam int MAXC = 255;

  logic       rclk = 1'b0;
  logic       rst;
  logic       cal_en;
  logic       cmp_in;
  logic       freeze;
  logic       we_csr;
  logic [7:0] from_csr;
  logic [7:0] z;
  logic [7:0] to_csr;
  logic       deltabit;
  logic       locked;
  logic       update_pulse;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  int exp_q[$];

  // Reference model: codes, vote tally, last step direction, reversals,
  // step decided but not yet applied, and round timing.
  int m_code;
  int m_z;
  int m_votes;
  int m_dir;
  int m_rev;
  int m_pending;
  int m_last_sample;
  int m_next;
  bit m_freeze;

  bw_io_ddr_impctl_cal #(
    .CODE_W(8), .FILT_DEPTH(4), .SETTLE_CYC(7), .DELTA_THR(2)
  ) dut (
    .rclk(rclk), .rst(rst), .cal_en(cal_en), .cmp_in(cmp_in), .freeze(freeze),
    .we_csr(we_csr), .from_csr(from_csr), .z(z), .to_csr(to_csr),
    .deltabit(deltabit), .locked(locked), .update_pulse(update_pulse)
  );

  // Free-running clock.
  always #5 rclk = ~rclk;

  // Rising-edge counter used as the bench timeline.
  always @(posedge rclk) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", name, actual, expected, edge_cnt);
    end
  endtask

  // Monitor: every update pulse must match the next predicted applied code.
  always @(negedge rclk) begin
    if (update_pulse === 1'b1) begin
      if (exp_q.size() == 0) checkOutput("unexpected_update_z", int'(z), -1);
      else checkOutput("update_z", int'(z), exp_q.pop_front());
    end
  end

  task automatic wait_until(input int t);
    while (edge_cnt < t) begin
      @(posedge rclk);
      #1;
    end
  endtask

  // z follows the tracking code whenever it is not frozen.
  task automatic model_sync();
    if (!m_freeze && (m_z != m_code)) begin
      exp_q.push_back(m_code);
      m_z = m_code;
    end
  endtask

  task automatic model_step();
    int nc;
    if (m_pending == 0) return;
    nc = m_code + m_pending;
    if (nc >= 0 && nc <= MAXC) begin
      if (m_dir != 0 && m_dir != m_pending && m_rev < 2) m_rev++;
      m_dir  = m_pending;
      m_code = nc;
    end
    m_pending = 0;
  endtask

  task automatic model_vote(input bit c);
    if (c) begin
      if (m_votes < 0) m_votes = 0;
      m_votes++;
    end else begin
      if (m_votes > 0) m_votes = 0;
      m_votes--;
    end
    if (m_votes == 4) begin
      m_pending = -1;
      m_votes   = 0;
    end else if (m_votes == -4) begin
      m_pending = 1;
      m_votes   = 0;
    end
  endtask

  task automatic model_clear_history();
    m_votes = 0; m_pending = 0; m_rev = 0; m_dir = 0;
  endtask

  // Start of a sample round: drive comparator/freeze, predict z updates.
  task automatic applyStimulus(input bit c, input bit f);
    int gap;
    gap = (m_pending != 0) ? 9 : 8;
    cmp_in   = c;
    freeze   = f;
    m_freeze = f;
    model_sync();
    model_step();
    model_sync();
    m_next = m_last_sample + gap;
  endtask

  // End of a sample round: check settled outputs, then count the vote.
  task automatic finish_round();
    int d;
    wait_until(m_next);
    d = (m_code > m_z) ? m_code - m_z : m_z - m_code;
    checkOutput("to_csr", int'(to_csr), m_code);
    checkOutput("z", int'(z), m_z);
    checkOutput("locked", int'(locked), (m_rev >= 2) ? 1 : 0);
    checkOutput("deltabit", int'(deltabit), (d >= 2) ? 1 : 0);
    model_vote(cmp_in);
    m_last_sample = m_next;
  endtask

  task automatic run_round(input bit c, input bit f);
    applyStimulus(c, f);
    finish_round();
  endtask

  task automatic start_cal();
    cal_en = 1'b1;
    @(posedge rclk);
    #1;
    m_last_sample = edge_cnt;
    m_votes = 0;
    m_pending = 0;
  endtask

  task automatic stop_cal();
    cal_en = 1'b0;
    repeat (3) begin
      @(posedge rclk);
      #1;
    end
    model_clear_history();
    checkOutput("idle_to_csr", int'(to_csr), m_code);
    checkOutput("idle_z", int'(z), m_z);
    checkOutput("idle_locked", int'(locked), 0);
  endtask

  task automatic csr_write(input int x);
    we_csr   = 1'b1;
    from_csr = x[7:0];
    model_clear_history();
    if (m_z != x) exp_q.push_back(x);
    m_code = x;
    m_z    = x;
    @(posedge rclk);
    #1;
    we_csr = 1'b0;
    m_last_sample = edge_cnt;
    checkOutput("csr_to_csr", int'(to_csr), x);
    checkOutput("csr_z", int'(z), x);
    checkOutput("csr_locked", int'(locked), 0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) begin
      @(posedge rclk);
      #1;
    end
    model_clear_history();
    m_code = MID;
    m_z    = MID;
    checkOutput("rst_z", int'(z), MID);
    checkOutput("rst_to_csr", int'(to_csr), MID);
    checkOutput("rst_locked", int'(locked), 0);
    checkOutput("rst_deltabit", int'(deltabit), 0);
    checkOutput("rst_update_pulse", int'(update_pulse), 0);
    rst = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a randomized phase.
  initial begin
    int guard;
    int e0;
    int x;
    int bias;
    bit c;
    bit f;
    rst = 1'b1; cal_en = 1'b0; cmp_in = 1'b0; freeze = 1'b0;
    we_csr = 1'b0; from_csr = '0; m_freeze = 1'b0;
    do_reset(2);

    // First down-step lands on z 34 edges after cal_en is sampled.
    start_cal();
    e0 = m_last_sample;
    repeat (4) run_round(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    wait_until(e0 + 33);
    checkOutput("first_step_pre_z", int'(z), 128);
    checkOutput("first_step_pre_pulse", int'(update_pulse), 0);
    wait_until(e0 + 34);
    checkOutput("first_step_z", int'(z), 127);
    checkOutput("first_step_pulse", int'(update_pulse), 1);
    wait_until(e0 + 35);
    checkOutput("first_step_pulse_drop", int'(update_pulse), 0);
    finish_round();

    // Walk down to 120, reverse up to 121, back to 120: two reversals lock.
    guard = 0;
    while (m_code != 120 && guard < 100) begin run_round(1'b1, 1'b0); guard++; end
    guard = 0;
    while (m_code != 121 && guard < 20) begin run_round(1'b0, 1'b0); guard++; end
    checkOutput("one_reversal_unlocked", int'(locked), 0);
    guard = 0;
    while (!(m_code == 120 && m_rev >= 2) && guard < 20) begin run_round(1'b1, 1'b0); guard++; end
    checkOutput("two_reversals_locked", int'(locked), 1);

    // Reset mid-SETTLE while locked, then re-enter calibration.
    repeat (3) begin @(posedge rclk); #1; end
    checkOutput("locked_before_rst", int'(locked), 1);
    do_reset(1);
    start_cal();

    // Alternating comparator never completes a filter window.
    for (int i = 0; i < 12; i++) run_round(i[0], 1'b0);
    checkOutput("toggle_code_mid", int'(to_csr), 128);
    checkOutput("toggle_unlocked", int'(locked), 0);

    // Three down-steps while frozen, then release.
    guard = 0;
    while (m_code != 125 && guard < 40) begin run_round(1'b1, 1'b1); guard++; end
    checkOutput("frozen_z", int'(z), 128);
    checkOutput("frozen_deltabit", int'(deltabit), 1);
    applyStimulus(1'b0, 1'b0);
    wait_until(m_last_sample + 1);
    checkOutput("release_z", int'(z), 125);
    wait_until(m_last_sample + 2);
    checkOutput("release_deltabit", int'(deltabit), 0);
    finish_round();

    // Override to 0 then keep pushing down: code saturates.
    csr_write(0);
    repeat (10) run_round(1'b1, 1'b0);
    checkOutput("saturated_z", int'(z), 0);

    // CSR write in the same cycle as a pending STEP wins.
    csr_write(200);
    guard = 0;
    while (m_pending == 0 && guard < 10) begin run_round(1'b1, 1'b0); guard++; end
    x = $urandom_range(10, 190);
    csr_write(x);
    repeat (2) run_round(1'b0, 1'b0);

    // Randomized phase starting near the top of the range.
    csr_write(253);
    bias = 15;
    for (int i = 0; i < 80; i++) begin
      if (i % 20 == 0) bias = (bias == 15) ? 85 : 15;
      c = ($urandom_range(0, 99) < bias);
      f = ($urandom_range(0, 9) == 0) ? !m_freeze : m_freeze;
      run_round(c, f);
    end
    run_round(1'b1, 1'b0);

    // Disable drops any pending step and clears lock state.
    stop_cal();
    start_cal();
    for (int i = 0; i < 6; i++) run_round(1'($urandom_range(0, 1)), 1'b0);

    repeat (4) begin @(posedge rclk); #1; end
    checkOutput("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
